// File: rtl/ps2_host_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ps2_host_tx                                                 |
// | Purpose  : PS/2 host-to-device frame transmitter (inhibit, request,    |
// |            11-clock frame, ACK sampling). Optional frame watchdog      |
// |            enabled by defining PS2_TX_TIMEOUT_EN.                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int C_INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [C_INH_W-1:0] C_INH_LAST = C_INH_W'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQ     = 3'd2,
    S_BITS    = 3'd3,
    S_STOP    = 3'd4,
    S_ACK     = 3'd5,
    S_WAITREL = 3'd6,
    S_FIN     = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           csync_q, dsync_q;
  logic [C_INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [8:0]           shift_q, shift_d;
  logic                 clk_low_q, clk_low_d;
  logic                 data_low_q, data_low_d;
  logic                 ack_err_q, ack_err_d;
  logic                 w_fall;

  // Stage 2 low with stage 3 high marks a settled high-to-low transition
  assign w_fall = ~csync_q[1] & csync_q[2];

`ifdef PS2_TX_TIMEOUT_EN
  localparam int C_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYCLES - 1);

  logic [C_TO_W-1:0] wd_q, wd_d;
  logic              to_err_q, to_err_d;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wd_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q    <= S_IDLE;
      csync_q    <= 3'b111;
      dsync_q    <= 3'b111;
      inh_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      csync_q    <= {csync_q[1:0], ps2_clk};
      dsync_q    <= {dsync_q[1:0], ps2_data};
      inh_cnt_q  <= inh_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      ack_err_q  <= ack_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    ack_err_d  = ack_err_q;
`ifdef PS2_TX_TIMEOUT_EN
    to_err_d   = to_err_q;
    wd_d       = (state_q == S_IDLE) ? '0 : wd_q + 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        if (tx_valid) begin
          shift_d   = {~^tx_data, tx_data};
          inh_cnt_d = '0;
          bit_cnt_d = '0;
          clk_low_d = 1'b1;
          ack_err_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
          to_err_d  = 1'b0;
`endif
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Start bit goes low while the clock is still held, one cycle ahead
        if (inh_cnt_q == C_INH_LAST) begin
          data_low_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        clk_low_d = 1'b0;
        if (w_fall) begin
          data_low_d = ~shift_q[0];
          shift_d    = shift_q >> 1;
          bit_cnt_d  = 4'd1;
          state_d    = S_BITS;
        end
      end
      S_BITS: begin
        if (w_fall) begin
          data_low_d = ~shift_q[0];
          shift_d    = shift_q >> 1;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_fall) begin
          data_low_d = 1'b0;
          state_d    = S_ACK;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          ack_err_d = dsync_q[1];
          state_d   = S_WAITREL;
        end
      end
      S_WAITREL: begin
        if (csync_q[2] && dsync_q[2]) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if ((state_q != S_IDLE) && (state_q != S_FIN) && (wd_q == C_TO_LAST)) begin
      state_d    = S_FIN;
      clk_low_d  = 1'b0;
      data_low_d = 1'b0;
      ack_err_d  = 1'b0;
      to_err_d   = 1'b1;
    end
`endif
  end

  assign ps2_clk_low  = clk_low_q;
  assign ps2_data_low = data_low_q;
  assign tx_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign ack_err      = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module   : tb_ps2_host_tx                                              |
// | Purpose  : scoreboard bench for ps2_host_tx with a PS/2 device model.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 1000;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_w, ps2_data_w;
  logic       ps2_clk_low, ps2_data_low, tx_ready, busy, done, ack_err, timeout_err;

  assign ps2_clk_w  = dev_clk & ~ps2_clk_low;
  assign ps2_data_w = dev_data & ~ps2_data_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .clrn         (clrn),
    .ps2_clk      (ps2_clk_w),
    .ps2_data     (ps2_data_w),
    .ps2_clk_low  (ps2_clk_low),
    .ps2_data_low (ps2_data_low),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .ack_err      (ack_err),
    .timeout_err  (timeout_err)
  );

  typedef struct { logic [7:0] b; bit nack; bit tmo; time t_acc; } exp_t;
  typedef struct { logic [7:0] b; logic par; logic stop; } cap_t;

  exp_t exp_q[$];
  cap_t cap_q[$];
  int   tests = 0, fails = 0, done_cnt = 0, edge_cnt = 0;
  bit   dev_nack = 0, dev_mute = 0, dev_abort = 0;

  // Odd parity: the ninth bit makes the total count of ones odd
  function automatic logic ref_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return ((ones % 2) == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s actual=missing required=present at %0t", name, $time);
  endtask

  // Device model: clocks the frame, samples data on each rising edge
  task automatic run_frame();
    cap_t       c;
    logic [9:0] s;
    s = '0;
    edge_cnt = 0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk  = 1'b0;
      edge_cnt = i + 1;
      repeat (HALF) @(posedge clk);
      dev_clk = 1'b1;
      if (dev_abort) return;
      s[i] = ps2_data_w;
      repeat (HALF) @(posedge clk);
      if (dev_abort) return;
    end
    if (!dev_nack) dev_data = 1'b0;
    repeat (5) @(posedge clk);
    dev_clk  = 1'b0;
    edge_cnt = 11;
    repeat (HALF) @(posedge clk);
    dev_clk = 1'b1;
    repeat (3) @(posedge clk);
    dev_data = 1'b1;
    c.b    = s[7:0];
    c.par  = s[8];
    c.stop = s[9];
    cap_q.push_back(c);
  endtask

  initial begin : device
    forever begin
      @(posedge clk);
      if (!dev_mute && !dev_abort && ps2_clk_w === 1'b1 && ps2_data_w === 1'b0)
        run_frame();
    end
  end

  initial begin : monitor
    exp_t e;
    cap_t c;
    bit   chk_rdy;
    int   cyc;
    chk_rdy = 0;
    forever begin
      @(negedge clk);
      if (chk_rdy) begin
        check("ready_after_done", tx_ready, 1);
        chk_rdy = 0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("ready_in_fin", tx_ready, 0);
        chk_rdy = 1;
        if (exp_q.size() == 0) begin
          flag("unexpected_done_no_request");
        end else begin
          e = exp_q.pop_front();
          check("ack_err", ack_err, (e.nack && !e.tmo));
          check("timeout_err", timeout_err, e.tmo);
          if (e.tmo) begin
            cyc = int'(($time - e.t_acc) / 10);
            check("timeout_latency_in_window", (cyc >= TO - 2 && cyc <= TO + 2), 1);
            check("lines_released_on_timeout", {ps2_clk_low, ps2_data_low}, 0);
          end else if (cap_q.size() == 0) begin
            flag("device_frame_missing");
          end else begin
            c = cap_q.pop_front();
            check("frame_byte", c.b, e.b);
            check("frame_parity", c.par, ref_parity(e.b));
            check("frame_stop", c.stop, 1);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit nack, input bit poke, input bit tmo);
    exp_t e;
    int   n, d0;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) flag("ready_before_send");
    dev_nack = nack;
    dev_mute = tmo;
    d0       = done_cnt;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    e.b = b; e.nack = nack; e.tmo = tmo; e.t_acc = $time;
    exp_q.push_back(e);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    if (poke) begin
      repeat (50) @(negedge clk);
      check("ready_while_busy", tx_ready, 0);
      check("busy_in_frame", busy, 1);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      repeat (3) @(negedge clk);
      tx_valid = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) flag("frame_done");
    repeat (3) @(negedge clk);
    dev_mute = 0;
  endtask

  initial begin : stimulus
    int n, d0;
    repeat (3) @(negedge clk);
    check("rst_clk_low", ps2_clk_low, 0);
    check("rst_data_low", ps2_data_low, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hED, 0, 0, 0);
    send(8'h00, 0, 0, 0);
    send(8'h01, 0, 0, 0);
    send(8'hF4, 1, 0, 0);
    send(8'hA3, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      send(8'($urandom), ($urandom_range(0, 3) == 0), 0, 0);

    // Reset in the middle of a frame
    @(negedge clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    n = 0;
    while (edge_cnt != 4 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (edge_cnt != 4) flag("reach_edge4");
    repeat (8) @(negedge clk);
    d0        = done_cnt;
    clrn      = 1'b0;
    dev_abort = 1;
    @(posedge clk);
    #1;
    check("midrst_clk_low", ps2_clk_low, 0);
    check("midrst_data_low", ps2_data_low, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (2 * HALF + 30) @(negedge clk);
    dev_abort = 0;
    check("midrst_no_done", done_cnt, d0);

    send(8'h5A, 0, 0, 0);
`ifdef PS2_TX_TIMEOUT_EN
    send(8'h99, 0, 0, 1);
    send(8'hC3, 0, 0, 0);
`endif

    repeat (10) @(negedge clk);
    if (exp_q.size() != 0) flag("pending_expected_empty");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 750000, watchdog limit in clk cycles for one whole frame (15 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port clrn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port ps2_clk  input  1  sensed PS/2 clock line (asynchronous).
REQ-006 SHALL have port ps2_data  input  1  sensed PS/2 data line (asynchronous).
REQ-007 SHALL have port ps2_clk_low  output  1  1 = pull PS/2 clock low; 0 = release the line.
REQ-008 SHALL have port ps2_data_low  output  1  1 = pull PS/2 data low; 0 = release the line.
REQ-009 SHALL have port tx_data  input  8  command byte to send to the device.
REQ-010 SHALL have port tx_valid  input  1  send request.
REQ-011 SHALL have port tx_ready  output  1  1 in IDLE only; a send is accepted when tx_valid and tx_ready are both 1.
REQ-012 SHALL have port busy  output  1  1 in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at the end of every frame.
REQ-014 SHALL have port ack_err  output  1  valid when done is 1: the device did not drive ACK low.
REQ-015 SHALL have port timeout_err  output  1  valid when done is 1: the frame was aborted by the watchdog.

Function
REQ-016 SHALL pass ps2_clk and ps2_data through 3-flop synchronizers; a ps2_clk falling edge is detected as stage2 = 0 and stage3 = 1.
REQ-017 SHALL use the states IDLE, INHIBIT, REQ, BITS, STOP, ACK, WAITREL and FIN.
REQ-018 On acceptance, SHALL latch tx_data, compute odd parity (parity = ~^tx_data), go to INHIBIT and assert ps2_clk_low.
REQ-019 In INHIBIT, SHALL count INHIBIT_CYCLES clk cycles.
REQ-020 On the last INHIBIT cycle, SHALL assert ps2_data_low (start bit) and go to REQ; ps2_clk_low deasserts 1 cycle later, so data falls before clock is released.
REQ-021 In REQ/BITS, SHALL shift one bit per detected ps2_clk falling edge: edges 1-8 present data bits LSB first, and edge 9 presents parity.
REQ-022 SHALL set ps2_data_low = ~bit for each presented bit.
REQ-023 On falling edge 10, SHALL release data (stop bit = 1) and enter ACK.
REQ-024 On falling edge 11 in ACK, SHALL sample synchronized ps2_data: 0 means ack_err = 0, 1 means ack_err = 1; then go to WAITREL.
REQ-025 WAITREL SHALL wait until both synchronized lines are 1, then go to FIN.
REQ-026 FIN SHALL pulse done for 1 cycle and return to IDLE; tx_ready is 1 on the following cycle.
REQ-027 tx_valid while busy SHALL be ignored; requests are not queued.
REQ-028 tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-029 Falling edges seen in IDLE or INHIBIT SHALL be ignored; this covers device-to-host traffic.
REQ-030 ps2_clk_low and ps2_data_low SHALL never both be asserted outside the INHIBIT-to-REQ transition.

Reset
REQ-031 With clrn = 0 at a clk edge, SHALL enter IDLE from any state, including mid-frame.
REQ-032 Reset values SHALL be: ps2_clk_low = 0, ps2_data_low = 0, tx_ready = 1, busy = 0, done = 0, ack_err = 0, timeout_err = 0, counters and shift register all 0.
REQ-033 A reset during a frame SHALL release both lines immediately and SHALL NOT pulse done.

Configuration
REQ-034 Macro PS2_TX_TIMEOUT_EN defined: a watchdog counts from acceptance.
REQ-035 With the macro defined, if the watchdog reaches TIMEOUT_CYCLES before FIN, SHALL release both lines and go to FIN with timeout_err = 1 and ack_err = 0.
REQ-036 With the macro defined, the watchdog SHALL reset on every return to IDLE.
REQ-037 Macro undefined: no watchdog logic, timeout_err tied 0, and the block waits indefinitely for device clocks.

Verification
REQ-038 Nominal: INHIBIT_CYCLES = 20, send 0xED, device model clocks 11 pulses and ACKs low -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, done pulse, ack_err = 0.
REQ-039 Parity: send 0x00 -> parity bit 1; send 0x01 -> parity bit 0.
REQ-040 NACK: device leaves data high at edge 11 while sending 0xF4 -> done with ack_err = 1.
REQ-041 Busy: tx_valid with 0x55 during a frame -> ignored; only the first byte appears on the wire; tx_ready = 0 until the cycle after done.
REQ-042 Reset mid-frame: clrn low after edge 4 -> next cycle both line-drive outputs = 0, IDLE, no done pulse.
REQ-043 Timeout (macro defined, TIMEOUT_CYCLES = 1000): device never clocks -> done at acceptance + 1000 cycles (±2), timeout_err = 1, lines released.
